// File: rtl/light_pkg.sv
//------------------------------------------------------------------------------
// light_pkg
// Shared mode encoding and scene lookup table for the light sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package light_pkg;

   // Sequencing modes, encoded as they arrive on the mode input.
   typedef enum logic [1:0] {
      MODE_OFF    = 2'd0,
      MODE_STEADY = 2'd1,
      MODE_BLINK  = 2'd2,
      MODE_CHASE  = 2'd3
   } mode_t;

   // Bit n is set when scene n (sel[4:2] == n) is lit: scenes 0,1,3,4.
   localparam logic [7:0] LIT_TABLE = 8'b0001_1011;

   function automatic logic decode_lit(input logic [2:0] scene);
      return LIT_TABLE[scene];
   endfunction

endpackage

`default_nettype wire

// File: rtl/light_prescaler.sv
//------------------------------------------------------------------------------
// light_prescaler
// Free-running divide-by-TICK_DIV counter producing a step strobe on the
// cycle it wraps. Clear restarts the count from zero.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module light_prescaler
   import light_pkg::*;
#(
   parameter int TICK_DIV = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clear,
   output logic step
);

   // A one-state counter still needs a single bit to exist.
   localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] count;

   // Step fires on the enabled edge where the counter wraps.
   assign step = en && (count == CNT_LAST);

   // Count enabled cycles, wrapping at TICK_DIV-1; clear has priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en) begin
         count <= step ? '0 : count + CNT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/light_sequencer.sv
//------------------------------------------------------------------------------
// light_sequencer
// Captures a scene/mode on a load strobe and drives NUM_LINES light lines
// off, steady, blinking or chasing, stepped by an internal prescaler.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module light_sequencer
   import light_pkg::*;
#(
   parameter int NUM_LINES   = 3,
   parameter int SEL_W       = 6,
   parameter int TICK_DIV    = 50000,
   parameter int BLINK_TICKS = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 load,
   input  logic [SEL_W-1:0]     sel,
   input  logic [1:0]           mode,
   output logic [NUM_LINES-1:0] lines,
   output logic                 lit,
   output logic                 tick
);

   localparam int                BLINK_W    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

   mode_t                mode_q;
   logic [BLINK_W-1:0]   blink_cnt;
   logic                 phase;
   logic                 step;
   logic                 lit_dec;
   logic                 blink_wrap;
   logic                 phase_next;
   logic [NUM_LINES-1:0] lines_rot;
   logic [NUM_LINES-1:0] load_lines;
   logic [NUM_LINES-1:0] step_lines;
   logic                 unused_sel;

   // Only sel[4:2] selects the scene; the remaining bits are don't-care.
   assign lit_dec    = decode_lit(sel[4:2]);
   assign unused_sel = ^sel;

   // A load restarts the step timebase so the first step is a full period away.
   light_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .clear (load),
      .step  (step)
   );

   // Rotate left with wrap; a single line has nothing to rotate into.
   generate
      if (NUM_LINES > 1) begin : g_rot
         assign lines_rot = {lines[NUM_LINES-2:0], lines[NUM_LINES-1]};
      end else begin : g_no_rot
         assign lines_rot = lines;
      end
   endgenerate

   assign blink_wrap = (blink_cnt == BLINK_LAST);
   assign phase_next = blink_wrap ? ~phase : phase;

   // Initial line pattern for the mode being loaded.
   always_comb begin
      load_lines = '0;
      case (mode_t'(mode))
         MODE_STEADY,
         MODE_BLINK:  load_lines = {NUM_LINES{lit_dec}};
         MODE_CHASE:  load_lines = NUM_LINES'(lit_dec);
         default:     load_lines = '0;
      endcase
   end

   // Line pattern after a step event in the captured mode.
   always_comb begin
      step_lines = '0;
      case (mode_q)
         MODE_STEADY: step_lines = {NUM_LINES{lit}};
         MODE_BLINK:  step_lines = phase_next ? {NUM_LINES{lit}} : '0;
         MODE_CHASE:  step_lines = lines_rot;
         default:     step_lines = '0;
      endcase
   end

   // Capture on load, advance on step; load wins and swallows a coincident wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q    <= MODE_OFF;
         lit       <= 1'b0;
         blink_cnt <= '0;
         phase     <= 1'b1;
         lines     <= '0;
         tick      <= 1'b0;
      end else begin
         tick <= step && !load;
         if (load) begin
            mode_q    <= mode_t'(mode);
            lit       <= lit_dec;
            blink_cnt <= '0;
            phase     <= 1'b1;
            lines     <= load_lines;
         end else if (step) begin
            blink_cnt <= blink_wrap ? '0 : blink_cnt + BLINK_W'(1);
            phase     <= phase_next;
            lines     <= step_lines;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_light_sequencer.sv
//------------------------------------------------------------------------------
// tb_light_sequencer
// Self-checking bench for light_sequencer (NUM_LINES=3, TICK_DIV=4,
// BLINK_TICKS=2) with a per-cycle expectation queue.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_light_sequencer;

   localparam int N  = 3;
   localparam int SW = 6;
   localparam int TD = 4;
   localparam int BT = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic          load;
   logic [SW-1:0] sel;
   logic [1:0]    mode;
   logic [N-1:0]  lines;
   logic          lit;
   logic          tick;

   always #5 clk = ~clk;

   light_sequencer #(
      .NUM_LINES   (N),
      .SEL_W       (SW),
      .TICK_DIV    (TD),
      .BLINK_TICKS (BT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .load  (load),
      .sel   (sel),
      .mode  (mode),
      .lines (lines),
      .lit   (lit),
      .tick  (tick)
   );

   typedef struct packed {
      logic [N-1:0] e_lines;
      logic         e_lit;
      logic         e_tick;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   // Reference state: captured mode/lit and enabled cycles since last load/reset.
   logic [1:0] m_mode;
   logic       m_lit;
   int         m_k;

   function automatic logic ref_lit(input logic [SW-1:0] s);
      case (s[4:2])
         3'd0, 3'd1, 3'd3, 3'd4: return 1'b1;
         default:                return 1'b0;
      endcase
   endfunction

   function automatic exp_t model_out(input logic t);
      exp_t r;
      int   steps;
      steps    = m_k / TD;
      r.e_lit  = m_lit;
      r.e_tick = t;
      case (m_mode)
         2'd0:    r.e_lines = '0;
         2'd1:    r.e_lines = {N{m_lit}};
         2'd2:    r.e_lines = (((steps / BT) % 2) == 0) ? {N{m_lit}} : '0;
         default: r.e_lines = m_lit ? (N'(1) << (steps % N)) : '0;
      endcase
      return r;
   endfunction

   task automatic model_reset();
      m_mode = 2'd0;
      m_lit  = 1'b0;
      m_k    = 0;
      sb.delete();
   endtask

   // Predict the upcoming edge from the driven inputs, then take the edge.
   task automatic cycle();
      logic t;
      t = 1'b0;
      if (load) begin
         m_mode = mode;
         m_lit  = ref_lit(sel);
         m_k    = 0;
      end else if (en) begin
         m_k++;
         t = ((m_k % TD) == 0);
      end
      sb.push_back(model_out(t));
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      rst_n = 1'b0; en = 1'b0; load = 1'b0; sel = '0; mode = 2'd0;
      model_reset();
      #1;
      checks++;
      if ({lines, lit, tick} !== {3'b000, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state lines=%b lit=%b tick=%b required 000/0/0", lines, lit, tick);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cycle();
         e = sb.pop_front();
         checks++;
         if ({lines, lit, tick} !== e) begin
            errors++;
            $display("FAIL post_reset cyc%0d lines=%b lit=%b tick=%b required %b/%b/%b",
                     i, lines, lit, tick, e.e_lines, e.e_lit, e.e_tick);
         end
      end
   endtask

   task automatic test_steady();
      exp_t e;
      int   ticks;
      sel = 6'b000100; mode = 2'd1; load = 1'b1;
      cycle();
      load = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({lines, lit, tick} !== e || lines !== 3'b111 || lit !== 1'b1) begin
         errors++;
         $display("FAIL steady_load lines=%b lit=%b tick=%b required 111/1/0", lines, lit, tick);
      end
      ticks = 0;
      for (int i = 0; i < 40; i++) begin
         cycle();
         e = sb.pop_front();
         ticks += int'(tick);
         checks++;
         if ({lines, lit, tick} !== e) begin
            errors++;
            $display("FAIL steady cyc%0d lines=%b lit=%b tick=%b required %b/%b/%b",
                     i, lines, lit, tick, e.e_lines, e.e_lit, e.e_tick);
         end
      end
      checks++;
      if (ticks != 10) begin
         errors++;
         $display("FAIL steady_tick_count got=%0d required=10", ticks);
      end
   endtask

   task automatic test_scene();
      exp_t e;
      logic [SW-1:0] scenes [4] = '{6'b001000, 6'b110000, 6'b100000, 6'b011100};
      for (int i = 0; i < 4; i++) begin
         sel = scenes[i]; mode = 2'd1; load = 1'b1;
         cycle();
         load = 1'b0;
         for (int j = 0; j < 3; j++) begin
            e = sb.pop_front();
            checks++;
            if ({lines, lit, tick} !== e) begin
               errors++;
               $display("FAIL scene sel=%b cyc%0d lines=%b lit=%b tick=%b required %b/%b/%b",
                        scenes[i], j, lines, lit, tick, e.e_lines, e.e_lit, e.e_tick);
            end
            cycle();
         end
         void'(sb.pop_front());
      end
   endtask

   task automatic test_chase();
      exp_t e;
      sel = '0; mode = 2'd3; load = 1'b1;
      cycle();
      load = 1'b0;
      e = sb.pop_front();
      checks++;
      if (lines !== 3'b001 || {lines, lit, tick} !== e) begin
         errors++;
         $display("FAIL chase_load lines=%b required 001", lines);
      end
      // 4 clocks to 010, 5 frozen clocks, then 4 more to 100, 4 more to 001.
      for (int i = 1; i <= 17; i++) begin
         en = !(i >= 5 && i <= 9);
         cycle();
         e = sb.pop_front();
         checks++;
         if ({lines, lit, tick} !== e) begin
            errors++;
            $display("FAIL chase cyc%0d lines=%b lit=%b tick=%b required %b/%b/%b",
                     i, lines, lit, tick, e.e_lines, e.e_lit, e.e_tick);
         end
         if (i == 9 && (lines !== 3'b010 || tick !== 1'b0)) begin
            errors++; checks++;
            $display("FAIL chase_frozen lines=%b tick=%b required 010/0", lines, tick);
         end else if (i == 9) checks++;
         if (i == 13 && lines !== 3'b100) begin
            errors++; checks++;
            $display("FAIL chase_resume lines=%b required 100", lines);
         end else if (i == 13) checks++;
         if (i == 17 && lines !== 3'b001) begin
            errors++; checks++;
            $display("FAIL chase_wrap lines=%b required 001", lines);
         end else if (i == 17) checks++;
      end
      en = 1'b1;
   endtask

   task automatic test_blink();
      exp_t e;
      sel = '0; mode = 2'd2; load = 1'b1;
      cycle();
      load = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         // Upstream selector wanders mid-blink with no load.
         if (i == 10) begin sel = 6'b001000; mode = 2'd0; end
         e = sb.pop_front();
         checks++;
         if ({lines, lit, tick} !== e) begin
            errors++;
            $display("FAIL blink cyc%0d lines=%b lit=%b tick=%b required %b/%b/%b",
                     i - 1, lines, lit, tick, e.e_lines, e.e_lit, e.e_tick);
         end
         cycle();
      end
      void'(sb.pop_front());
      checks++;
      if (lines !== 3'b111) begin
         errors++;
         $display("FAIL blink_third_phase lines=%b required 111", lines);
      end
   endtask

   task automatic test_load_wrap_reset();
      exp_t e;
      sel = '0; mode = 2'd3; load = 1'b1;
      cycle();
      load = 1'b0;
      void'(sb.pop_front());
      for (int i = 0; i < 5; i++) begin cycle(); void'(sb.pop_front()); end
      while (((m_k + 1) % TD) != 0) begin cycle(); void'(sb.pop_front()); end
      // This load lands on a wrap edge.
      load = 1'b1;
      cycle();
      load = 1'b0;
      for (int i = 0; i < 5; i++) begin
         e = sb.pop_front();
         checks++;
         if ({lines, lit, tick} !== e) begin
            errors++;
            $display("FAIL load_on_wrap cyc%0d lines=%b lit=%b tick=%b required %b/%b/%b",
                     i, lines, lit, tick, e.e_lines, e.e_lit, e.e_tick);
         end
         if (i < 4 && (lines !== 3'b001 || tick !== 1'b0)) begin
            errors++;
            $display("FAIL load_on_wrap_restart cyc%0d lines=%b tick=%b required 001/0", i, lines, tick);
         end
         cycle();
      end
      void'(sb.pop_front());
      // Asynchronous reset between edges.
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({lines, lit, tick} !== {3'b000, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset lines=%b lit=%b tick=%b required 000/0/0", lines, lit, tick);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cycle();
         e = sb.pop_front();
         checks++;
         if ({lines, lit, tick} !== e) begin
            errors++;
            $display("FAIL after_reset cyc%0d lines=%b lit=%b tick=%b required %b/%b/%b",
                     i, lines, lit, tick, e.e_lines, e.e_lit, e.e_tick);
         end
      end
   endtask

   task automatic test_off_and_disabled_load();
      exp_t e;
      int   ticks;
      sel = '0; mode = 2'd0; load = 1'b1;
      cycle();
      load  = 1'b0;
      ticks = 0;
      for (int i = 0; i < 9; i++) begin
         e = sb.pop_front();
         ticks += int'(tick);
         checks++;
         if ({lines, lit, tick} !== e) begin
            errors++;
            $display("FAIL off cyc%0d lines=%b lit=%b tick=%b required %b/%b/%b",
                     i, lines, lit, tick, e.e_lines, e.e_lit, e.e_tick);
         end
         cycle();
      end
      void'(sb.pop_front());
      checks++;
      if (ticks != 2) begin
         errors++;
         $display("FAIL off_tick_count got=%0d required=2", ticks);
      end
      en = 1'b0; mode = 2'd1; load = 1'b1;
      cycle();
      load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         e = sb.pop_front();
         checks++;
         if ({lines, lit, tick} !== e || lines !== 3'b111) begin
            errors++;
            $display("FAIL load_while_disabled cyc%0d lines=%b lit=%b tick=%b required %b/%b/%b",
                     i, lines, lit, tick, e.e_lines, e.e_lit, e.e_tick);
         end
         cycle();
      end
      void'(sb.pop_front());
      en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_steady();
      test_scene();
      test_chase();
      test_blink();
      test_load_wrap_reset();
      test_off_and_disabled_load();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/light_sequencer.md
Name: light_sequencer

Overview:
Parametrised successor to the fixed 3-line light decoder. Decodes a 6-bit scene select into a lit/unlit decision, as before. Drives NUM_LINES light lines in one of four modes: off, steady, blink or chase, timed by an internal prescaler. Scene and mode are captured on a load strobe, so the upstream selector logic can change freely between loads.

Parameters:
NUM_LINES, 3, number of light lines driven (>=1)
SEL_W, 6, scene select width (>=5; only sel[4:2] is decoded, upper bits ignored)
TICK_DIV, 50000, clk cycles per step tick (>=1)
BLINK_TICKS, 8, ticks per blink half-period (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  count enable; low freezes prescaler, step counters and lines
load  in  1  capture strobe for sel/mode, one cycle
sel  in  SEL_W  scene select
mode  in  2  0 off, 1 steady, 2 blink, 3 chase
lines  out  NUM_LINES  registered light drive, 1 = on
lit  out  1  registered decode of captured scene
tick  out  1  registered one-cycle pulse, cycle after each prescaler wrap

Behaviour:
- Reset (async assert, sync release): lines=0, lit=0, tick=0, captured mode=off, prescaler=0, blink counter=0, blink phase=on.
- Scene decode: lit = 1 iff sel[4:2] is in {0,1,3,4}; lit = 0 for {2,5,6,7}.
- Load: on an edge with load=1, capture mode and decoded lit, clear prescaler and blink counter, and set blink phase=on. On that same edge, lines load the mode's initial value: off -> 0; steady/blink -> all lit; chase -> lit ? one-hot bit 0 : 0. Latency is 1 clock.
- Priority: load beats en=0 and beats a coincident prescaler wrap. A wrap on the load edge is discarded.
- Prescaler: increments on each en=1 cycle. At TICK_DIV-1 it wraps to 0, which is a step event on that edge; tick goes high the following cycle. With TICK_DIV=1, every enabled cycle is a step event.
- Off: lines=0. Prescaler keeps running, so tick still pulses.
- Steady: lines = all lit, constant.
- Blink: each step event increments the blink counter. At BLINK_TICKS-1 the counter wraps and the phase toggles. lines = phase ? all lit : 0. First off-phase occurs TICK_DIV*BLINK_TICKS enabled clocks after load.
- Chase: each step event rotates lines left by one with wrap (MSB -> bit 0). Stays 0 when lit=0. With NUM_LINES=1, chase behaves as steady.
- en=0: all state frozen and tick=0; outputs hold their value.
- Mode/sel changes without load have no effect.
- Async reset mid-sequence returns immediately to the reset values; sequencing restarts only on the next load.

Decomposition:
- Shared package light_pkg holds:
  - mode constants MODE_OFF=2'd0, MODE_STEADY=2'd1, MODE_BLINK=2'd2, MODE_CHASE=2'd3;
  - LIT_TABLE=8'b0001_1011, indexed by sel[4:2].
- One sub-module, light_prescaler: counter plus wrap/step output, with clear and en inputs, parametrised by TICK_DIV.

Test Plan (NUM_LINES=3, TICK_DIV=4, BLINK_TICKS=2):
1. Reset, then load sel=6'b000100, mode=1 -> one clock later lines=3'b111, lit=1; lines unchanged after 40 clocks; tick pulses every 4th clock.
2. Load sel=6'b001000 (sel[4:2]=2), mode=1 -> lines=0, lit=0. Then load sel=6'b110000 (sel[4:2]=4) -> lines=3'b111.
3. Load sel=0, mode=3 -> lines=001, then 010 after 4 clocks, 100 after 8, 001 after 12. Deassert en for 5 clocks at the 010 step -> lines stay 010, tick stays 0, and rotation resumes with a 4-clock interval after re-enable.
4. Load sel=0, mode=2 -> lines 111 for 8 clocks, 000 for 8, 111 again. Mid-blink, change sel/mode without load -> no change.
5. Assert load on the same edge as a prescaler wrap, in chase mode -> lines restart at 001 and the discarded step never occurs. Assert rst_n=0 mid-chase -> lines=0 immediately without a clock.
6. Load mode=0 -> lines=0 while tick keeps pulsing every 4 clocks. Load while en=0 -> the capture still takes effect.
